// File: rtl/burst_pkg.sv
// Shared types and defaults for the ultrasound burst sequencer and the sin core wrapper.
package burst_pkg;

  localparam int PW_DEF      = 16;
  localparam int CW_DEF      = 8;
  localparam int LW_DEF      = 16;
  // phase_in -> x_out latency of the sin core; tx_en is delayed by this much
  localparam int SIN_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    LISTEN = 2'd2
  } state_t;

endpackage

// File: rtl/burst_phase_acc.sv
// PW-bit phase accumulator: clear beats enable; wrap is the carry of the current add, valid when enabled.
// Latency: acc updates one clk after enable; wrap is combinational from acc and inc.
module burst_phase_acc
  import burst_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [PW-1:0] inc,
  output logic [PW-1:0] acc,
  output logic          wrap
);

  logic [PW:0] sum;

  assign sum  = {1'b0, acc} + {1'b0, inc};
  assign wrap = en & sum[PW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[PW-1:0];
    end
  end

endmodule

// File: rtl/ultrasound_burst_ctrl.sv
// Drives the sin core phase input with whole-cycle bursts followed by a listen window, optionally repeating.
// phase_out is combinational from state/accumulator; tx_en trails BURST by SIN_LAT clks to align with x_out.
module ultrasound_burst_ctrl
  import burst_pkg::*;
#(
  parameter int PW      = PW_DEF,
  parameter int CW      = CW_DEF,
  parameter int LW      = LW_DEF,
  parameter int SIN_LAT = SIN_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          repeat_en,
  input  logic [PW-1:0] freq_word,
  input  logic [CW-1:0] burst_cycles,
  input  logic [LW-1:0] listen_len,
  output logic [PW-1:0] phase_out,
  output logic          tx_en,
  output logic          tof_start,
  output logic          burst_done,
  output logic          listen_active,
  output logic          busy
);

  state_t state, state_nx;

  logic [PW-1:0]      fw_q;
  logic [CW-1:0]      cyc_q;
  logic [LW-1:0]      len_q;
  logic [CW-1:0]      cyc_cnt;
  logic [LW-1:0]      lst_cnt;
  logic [PW-1:0]      acc;
  logic               wrap;
  logic               in_burst;
  logic               in_listen;
  logic               accept;
  logic               last_wrap;
  logic               lst_last;
  logic               acc_clr;
  logic [SIN_LAT-1:0] tx_dly;
  logic               tx_en_d1;

  assign in_burst  = (state == BURST);
  assign in_listen = (state == LISTEN);
  assign accept    = (state == IDLE) && start && !abort && (freq_word != '0);
  assign last_wrap = in_burst && wrap && (cyc_cnt == cyc_q - CW'(1));
  // a zero-length window still lasts one clk
  assign lst_last  = in_listen && ((len_q == '0) || (lst_cnt == len_q - LW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = BURST;
      BURST:   if (last_wrap) state_nx = LISTEN;
      LISTEN:  if (lst_last)  state_nx = repeat_en ? BURST : IDLE;
      default:                state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw_q  <= '0;
      cyc_q <= '0;
      len_q <= '0;
    end else if (accept) begin
      fw_q  <= freq_word;
      cyc_q <= (burst_cycles == '0) ? CW'(1) : burst_cycles;
      len_q <= listen_len;
    end
  end

  // Clearing whenever the next state is not BURST leaves acc at 0 for every burst entry.
  assign acc_clr = abort || (state_nx != BURST);

  burst_phase_acc #(
    .PW (PW)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (in_burst),
    .inc   (fw_q),
    .acc   (acc),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      lst_cnt <= '0;
    end else begin
      if (abort || !in_burst) begin
        cyc_cnt <= '0;
      end else if (wrap) begin
        cyc_cnt <= cyc_cnt + CW'(1);
      end
      if (abort || !in_listen || lst_last) begin
        lst_cnt <= '0;
      end else begin
        lst_cnt <= lst_cnt + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_dly   <= '0;
      tx_en_d1 <= 1'b0;
    end else if (abort) begin
      tx_dly   <= '0;
      tx_en_d1 <= 1'b0;
    end else begin
      tx_dly[0] <= in_burst;
      for (int i = 1; i < SIN_LAT; i++) begin
        tx_dly[i] <= tx_dly[i-1];
      end
      tx_en_d1 <= tx_dly[SIN_LAT-1];
    end
  end

  assign phase_out     = in_burst ? acc : '0;
  assign tx_en         = tx_dly[SIN_LAT-1];
  assign tof_start     = tx_en & ~tx_en_d1;
  assign burst_done    = in_listen && (lst_cnt == '0);
  assign listen_active = in_listen;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_ultrasound_burst_ctrl.sv
// Directed bench for ultrasound_burst_ctrl; expected phase sequences are queued at start and popped during BURST.
module tb_ultrasound_burst_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        repeat_en;
  logic [15:0] freq_word;
  logic [7:0]  burst_cycles;
  logic [15:0] listen_len;
  logic [15:0] phase_out;
  logic        tx_en;
  logic        tof_start;
  logic        burst_done;
  logic        listen_active;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  int r_blen, r_txn, r_tofn, r_tofk, r_donen, r_donek, r_lstn, r_idlek;

  ultrasound_burst_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .repeat_en     (repeat_en),
    .freq_word     (freq_word),
    .burst_cycles  (burst_cycles),
    .listen_len    (listen_len),
    .phase_out     (phase_out),
    .tx_en         (tx_en),
    .tof_start     (tof_start),
    .burst_done    (burst_done),
    .listen_active (listen_active),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=no end of test expected=end within 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int fw, input int cyc);
    longint ce;
    longint len;
    ce  = (cyc == 0) ? 1 : cyc;
    len = (ce * 65536 + fw - 1) / fw;
    for (longint i = 0; i < len; i++) exp_q.push_back(16'((i * fw) & 16'hFFFF));
  endtask

  task automatic do_start(input logic [15:0] fw, input logic [7:0] cyc, input logic [15:0] len);
    freq_word    = fw;
    burst_cycles = cyc;
    listen_len   = len;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {phase_out, tx_en, tof_start, burst_done, listen_active, busy}, 32'd0);
  endtask

  task automatic run_burst(input int limit);
    r_blen = 0; r_txn = 0; r_tofn = 0; r_donen = 0; r_lstn = 0;
    r_tofk = -1; r_donek = -1; r_idlek = -1;
    for (int k = 0; k < limit; k++) begin
      if (k > 0) tick();
      if (busy && !listen_active) begin
        r_blen++;
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else check("phase", phase_out, exp_q.pop_front());
      end else begin
        check("phase_zero", phase_out, 32'd0);
      end
      if (tx_en) r_txn++;
      if (tof_start) begin r_tofn++; if (r_tofk < 0) r_tofk = k; end
      if (burst_done) begin r_donen++; if (r_donek < 0) r_donek = k; end
      if (listen_active) r_lstn++;
      if (k > 0 && !busy && !tx_en) begin r_idlek = k; break; end
    end
    check("timeout", 32'(r_idlek >= 0), 32'd1);
    check("sb_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int tofn, donen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    freq_word = '0; burst_cycles = '0; listen_len = '0;
    #3;
    check_all_zero("reset_outputs");
    #20 rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 32'd0);

    // 1: 3 cycles at quarter-turn steps; config inputs scrambled mid-burst must not matter
    push_burst(16'h4000, 3);
    do_start(16'h4000, 8'd3, 16'd10);
    freq_word = 16'h1234; burst_cycles = 8'd7; listen_len = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.pop_front();
    check("t1_phase_k1", phase_out, 32'h4000);
    run_burst(100);
    check("t1_burst_len", r_blen, 32'd11);
    check("t1_done_cnt", r_donen, 32'd1);
    check("t1_done_k", r_donek, 32'd11);
    check("t1_listen_len", r_lstn, 32'd10);
    check("t1_idle_k", r_idlek, 32'd21);

    // 2: same config, tx_en alignment
    push_burst(16'h4000, 3);
    do_start(16'h4000, 8'd3, 16'd10);
    run_burst(100);
    check("t2_burst_len", r_blen, 32'd12);
    check("t2_done_k", r_donek, 32'd12);
    check("t2_tx_width", r_txn, 32'd12);
    check("t2_tof_cnt", r_tofn, 32'd1);
    check("t2_tof_k", r_tofk, 32'd2);
    check("t2_idle_k", r_idlek, 32'd22);

    // 3: repeat mode, 4-clk bursts every 8 clks; repeat dropped inside the third window
    repeat_en = 1'b1;
    push_burst(16'h4000, 1); push_burst(16'h4000, 1); push_burst(16'h4000, 1);
    do_start(16'h4000, 8'd1, 16'd4);
    tofn = 0; donen = 0;
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) tick();
      check("t3_tx_en", tx_en, 32'(k >= 2 && ((k - 2) % 8) < 4));
      check("t3_busy", busy, 32'(k < 24));
      if (busy && !listen_active) begin
        if (exp_q.size() == 0) check("t3_sb_underflow", 32'(exp_q.size()), 32'd1);
        else check("t3_phase", phase_out, exp_q.pop_front());
      end
      if (tof_start) tofn++;
      if (burst_done) donen++;
      if (k == 21) repeat_en = 1'b0;
    end
    check("t3_tof_cnt", tofn, 32'd3);
    check("t3_done_cnt", donen, 32'd3);
    check("t3_sb_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // 4: abort at clk 5 of a burst
    do_start(16'h4000, 8'd3, 16'd10);
    repeat (5) tick();
    check("t4_tx_before", tx_en, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_all_zero("t4_after_abort");
    donen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (burst_done || busy || tx_en) donen++;
    end
    check("t4_quiet", donen, 32'd0);

    // 5: zero freq word ignored; zero cycles = one cycle; start+abort same clk ignored
    freq_word = 16'h0000; burst_cycles = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_fw0_busy", busy, 32'd0);
    tick();
    check("t5_fw0_busy2", busy, 32'd0);
    push_burst(16'h4000, 0);
    do_start(16'h4000, 8'd0, 16'd2);
    run_burst(100);
    check("t5_cyc0_len", r_blen, 32'd4);
    check("t5_cyc0_done", r_donen, 32'd1);
    freq_word = 16'h4000; burst_cycles = 8'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_all_zero("t5_start_abort");

    // 6: async reset mid-LISTEN, then a long fine-step burst
    do_start(16'h4000, 8'd1, 16'd10);
    for (int k = 0; k < 20 && !listen_active; k++) tick();
    check("t6_in_listen", listen_active, 32'd1);
    tick(); tick();
    #3 rst_n = 1'b0;
    #1 check_all_zero("t6_async_reset");
    #2 rst_n = 1'b1;
    tick();
    check("t6_idle_after_reset", busy, 32'd0);
    push_burst(16'h0003, 2);
    do_start(16'h0003, 8'd2, 16'd1);
    run_burst(50000);
    check("t6_burst_len", r_blen, 32'd43691);
    check("t6_done_cnt", r_donen, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
